// File: rtl/imm_gen_pkg.sv
// Shared opcodes, format codes and entry sizing for the registered RV32I immediate generator.
package imm_gen_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        FmtR   = 3'd0,
        FmtI   = 3'd1,
        FmtS   = 3'd2,
        FmtB   = 3'd3,
        FmtU   = 3'd4,
        FmtJ   = 3'd5,
        FmtZ   = 3'd6,
        FmtIll = 3'd7
    } fmt_e;

    // Buffer entry layout: {imm, fmt, illegal, instr}.
    function automatic int unsigned entry_width(input int unsigned xlen);
        return xlen + 3 + 1 + 32;
    endfunction

endpackage

// File: rtl/imm_gen_decode.sv
// Combinational opcode-driven immediate decoder. Defining IMM_GEN_SHAMT_CHECK_EN additionally
// flags malformed OP-IMM shift immediates as illegal.
module imm_gen_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o
);

    logic [6:0]  opcode;
    logic [31:0] imm32;
    fmt_e        fmt;

    assign opcode = instr_i[6:0];

    always_comb begin
        imm32     = '0;
        fmt       = FmtIll;
        illegal_o = 1'b0;
        case (opcode)
            OP: fmt = FmtR;
            OP_IMM, LOAD, JALR, FENCE: begin
                fmt   = FmtI;
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            SYSTEM: begin
                if (instr_i[14]) begin
                    fmt   = FmtZ;
                    imm32 = {27'b0, instr_i[19:15]};
                end else begin
                    fmt   = FmtI;
                    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                end
            end
            STORE: begin
                fmt   = FmtS;
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            BRANCH: begin
                fmt   = FmtB;
                imm32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            end
            LUI, AUIPC: begin
                fmt   = FmtU;
                imm32 = {instr_i[31:12], 12'b0};
            end
            JAL: begin
                fmt   = FmtJ;
                imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            end
            default: begin
                fmt       = FmtIll;
                illegal_o = 1'b1;
            end
        endcase
`ifdef IMM_GEN_SHAMT_CHECK_EN
        // SLLI/SRLI/SRAI: shamt[5] is only meaningful on RV64; upper funct bits must be 0 or SRA.
        if (opcode == OP_IMM && instr_i[13:12] == 2'b01) begin
            if (XLEN == 32 && instr_i[25]) begin
                illegal_o = 1'b1;
            end
            if (instr_i[31:26] != 6'b000000 && instr_i[31:26] != 6'b010000) begin
                illegal_o = 1'b1;
            end
        end
`endif
        // imm32[31] is the sign for every signed format and 0 for zimm/R/ILL.
        imm_o       = {XLEN{imm32[31]}};
        imm_o[31:0] = imm32;
    end

    assign fmt_o = fmt;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator behind a valid/ready 2-entry skid buffer.
// The IMM_GEN_SHAMT_CHECK_EN macro enables shift-immediate legality checking in the decoder.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned PASS_INSTR = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [31:0]     out_instr,
    output logic            out_illegal
);

    localparam int unsigned EntryW = entry_width(XLEN);

    logic [EntryW-1:0] mem_q [2];
    logic [EntryW-1:0] wr_entry;
    logic [EntryW-1:0] head;
    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              ready_q;
    logic              push, pop;

    logic [XLEN-1:0]   dec_imm;
    logic [2:0]        dec_fmt;
    logic              dec_ill;

    imm_gen_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i   (in_instr),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_ill)
    );

    assign wr_entry = {dec_imm, dec_fmt, dec_ill, (PASS_INSTR != 0) ? in_instr : 32'h0};

    // ready_q keeps in_ready low until the first edge after reset release.
    assign in_ready  = ready_q & (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (push && !pop) begin
                count_d = count_q + 2'd1;
            end else if (pop && !push) begin
                count_d = count_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            ready_q  <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= 1'b1;
            if (push) begin
                mem_q[wr_ptr_q] <= wr_entry;
            end
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign out_imm     = head[EntryW-1 -: XLEN];
    assign out_fmt     = head[35:33];
    assign out_illegal = head[32];
    assign out_instr   = head[31:0];

endmodule
